// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and helpers for the clock-enable divider bank.
// Optional feature macro used by this slice: CLKDIV_SQUARE_EN (square outputs).
package clkdiv_pkg;

  // Smallest usable divisor; a programmed 0 is promoted to this value.
  localparam int DIV_MIN = 1;

  // Widest divisor the normalise helper carries; CNT_W must not exceed it.
  localparam int DIV_MAX_W = 32;

  // Channel-select width: max(1, clog2(num_ch)) so a single channel still
  // gets a one-bit select port.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Effective divisor: 0 behaves as DIV_MIN, anything else passes through.
  function automatic logic [DIV_MAX_W-1:0] div_norm(input logic [DIV_MAX_W-1:0] div);
    return (div == '0) ? DIV_MAX_W'(DIV_MIN) : div;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel of clk_div_bank.
// Holds the period counter, the active and shadow divisors, the pending flag,
// the registered tick strobe and (with CLKDIV_SQUARE_EN) the square-wave flop.
// Divisor writes land in the shadow and only move to the active divisor at a
// period boundary or on a sync restart, so a running period is never cut short.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             tick,
  output logic             clk_out,
  output logic             pend
);

  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] div_a_q, div_a_d;
  logic [CNT_W-1:0] div_s_q, div_s_d;
  logic             pend_q,  pend_d;
  logic             tick_q,  tick_d;

  logic [CNT_W-1:0] n_eff;
  logic             at_wrap;
  logic             wrap_fire;

  // Effective divisor of the active setting and the last count of its period.
  always_comb begin
    n_eff   = CNT_W'(div_norm(DIV_MAX_W'(div_a_q)));
    at_wrap = (cnt_q == (n_eff - CNT_W'(1)));
  end

  // A boundary only happens on an enabled, non-restart cycle.
  assign wrap_fire = en && !sync && at_wrap;

  // Next-state logic: sync restart wins over run/freeze; a write that lands on
  // the same edge as a boundary is kept pending because the boundary consumes
  // the shadow value that was there before the write.
  always_comb begin
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_s_d = div_s_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    if (sync) begin
      cnt_d = '0;
      if (wr) begin
        div_a_d = wr_val;
        div_s_d = wr_val;
        pend_d  = 1'b0;
      end else if (pend_q) begin
        div_a_d = div_s_q;
        pend_d  = 1'b0;
      end
    end else begin
      if (en) begin
        if (at_wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (pend_q) begin
            div_a_d = div_s_q;
            pend_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      if (wr) begin
        div_s_d = wr_val;
        pend_d  = 1'b1;
      end
    end
  end

  // Channel state registers, cleared straight away by the async reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q   <= '0;
      div_a_q <= CNT_W'(DEFAULT_DIV);
      div_s_q <= CNT_W'(DEFAULT_DIV);
      pend_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_s_q <= div_s_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;
  assign pend = pend_q;

`ifdef CLKDIV_SQUARE_EN
  logic sq_q, sq_d;

  // Square output flips on every boundary and restarts low on sync.
  always_comb begin
    sq_d = sq_q;
    if (sync) begin
      sq_d = 1'b0;
    end else if (wrap_fire) begin
      sq_d = ~sq_q;
    end
  end

  // Square-wave toggle flop.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sq_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign clk_out = sq_q;
`else
  logic unused_wrap;
  assign unused_wrap = wrap_fire;
  assign clk_out     = 1'b0;
`endif

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: multi-channel clock-enable generator for the 100 MHz system
// clock (pixel tick, frame tick, animation and physics ticks).
// Each channel divides by its own runtime divisor and produces a one-cycle
// tick plus an optional 50% square output (enabled by CLKDIV_SQUARE_EN;
// without it clk_out is tied low).
// Writes aimed at a channel index past NUM_CH-1 are dropped.
module clk_div_bank
  import clkdiv_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = 16,
  parameter  int DEFAULT_DIV = 2,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              en,
  input  logic              sync,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] pend
);

  logic [NUM_CH-1:0] wr_sel;

  // Write-address decode: one-hot strobe for the addressed channel only.
  always_comb begin
    wr_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      wr_sel[k] = div_wr && (int'(div_ch) == k);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    clkdiv_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk),
      .clr_n   (clr_n),
      .en      (en),
      .sync    (sync),
      .wr      (wr_sel[k]),
      .wr_val  (div_val),
      .tick    (tick[k]),
      .clk_out (clk_out[k]),
      .pend    (pend[k])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed self-checking bench for clk_div_bank.
// Five channels are used so that a channel index past the last one exists.
module tb_clk_div_bank;

  localparam int NCH = 5;
  localparam int CW  = 16;
`ifdef CLKDIV_SQUARE_EN
  localparam bit SQUARE = 1'b1;
`else
  localparam bit SQUARE = 1'b0;
`endif

  logic           clk;
  logic           clr_n;
  logic           en;
  logic           sync;
  logic           div_wr;
  logic [2:0]     div_ch;
  logic [CW-1:0]  div_val;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] pend;

  int vectors     = 0;
  int miscompares = 0;

  logic [NCH-1:0] expClk;
  int             nDiv [NCH];

  clk_div_bank #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (2)
  ) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .en      (en),
    .sync    (sync),
    .div_wr  (div_wr),
    .div_ch  (div_ch),
    .div_val (div_val),
    .tick    (tick),
    .clk_out (clk_out),
    .pend    (pend)
  );

  // 100 MHz system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive every input for the next clock edge.
  task automatic applyStimulus(input logic e, input logic s, input logic w,
                               input logic [2:0] ch, input logic [CW-1:0] v);
    en      = e;
    sync    = s;
    div_wr  = w;
    div_ch  = ch;
    div_val = v;
  endtask

  // Advance one edge and settle just after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected tick vector at enabled count f since a restart with divisors nDiv.
  function automatic logic [NCH-1:0] tickPattern(input int f);
    logic [NCH-1:0] p;
    p = '0;
    for (int k = 0; k < NCH; k++) p[k] = ((f % nDiv[k]) == 0);
    return p;
  endfunction

  // Compare tick, pend and clk_out; square model flips on every expected tick.
  task automatic checkOutput(input string tag, input logic [NCH-1:0] expTick,
                             input logic [NCH-1:0] expPend, input bit restart);
    logic [NCH-1:0] expOut;
    if (restart) expClk = '0;
    else         expClk = expClk ^ expTick;
    expOut = expClk & {NCH{SQUARE}};
    vectors++;
    assert (tick === expTick) else begin
      miscompares++;
      $error("[TB] FAIL %s tick: observed %b expected %b", tag, tick, expTick);
    end
    vectors++;
    assert (pend === expPend) else begin
      miscompares++;
      $error("[TB] FAIL %s pend: observed %b expected %b", tag, pend, expPend);
    end
    vectors++;
    assert (clk_out === expOut) else begin
      miscompares++;
      $error("[TB] FAIL %s clk_out: observed %b expected %b", tag, clk_out, expOut);
    end
  endtask

  // Directed sequence of all scenarios.
  initial begin
    logic [NCH-1:0] t;
    logic [NCH-1:0] p;
    expClk = '0;
    clr_n  = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    #12;
    checkOutput("reset", '0, '0, 1'b1);
    clr_n = 1'b1;

    // Defaults: N=2 on every channel, ticks on even cycles.
    nDiv = '{2, 2, 2, 2, 2};
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    for (int f = 1; f <= 20; f++) begin
      cycle();
      checkOutput($sformatf("dflt f%0d", f), tickPattern(f), '0, 1'b0);
    end

    // ch1 -> 5 written with cnt=0: old period finishes first.
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd1, 16'd5);
    cycle();
    checkOutput("ch1 wr", '0, 5'b00010, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    cycle();
    checkOutput("ch1 apply", 5'b11111, '0, 1'b0);
    for (int f = 23; f <= 32; f++) begin
      t = tickPattern(f);
      t[1] = (((f - 22) % 5) == 0);
      cycle();
      checkOutput($sformatf("ch1 n5 f%0d", f), t, '0, 1'b0);
    end

    // Two writes to ch2 while frozen; only the last (7) is used.
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 16'd0);
    cycle();
    checkOutput("sync a", '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 16'd3);
    cycle();
    checkOutput("ch2 wr3", '0, 5'b00100, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 16'd7);
    cycle();
    checkOutput("ch2 wr7", '0, 5'b00100, 1'b0);
    nDiv = '{2, 5, 7, 2, 2};
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    for (int f = 1; f <= 16; f++) begin
      t = tickPattern(f);
      t[2] = (f == 2) || (f == 9) || (f == 16);
      p = (f == 1) ? 5'b00100 : 5'b00000;
      cycle();
      checkOutput($sformatf("ch2 last f%0d", f), t, p, 1'b0);
    end

    // ch0 N=4 via sync write, freeze at cnt=2 for 10 cycles.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 16'd4);
    cycle();
    checkOutput("sync wr ch0", '0, '0, 1'b1);
    nDiv = '{4, 5, 7, 2, 2};
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    for (int f = 1; f <= 2; f++) begin
      cycle();
      checkOutput($sformatf("pre hold f%0d", f), tickPattern(f), '0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      checkOutput($sformatf("hold %0d", i), '0, '0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    for (int f = 3; f <= 8; f++) begin
      cycle();
      checkOutput($sformatf("post hold f%0d", f), tickPattern(f), '0, 1'b0);
    end

    // Build N=2,3,4,5 then ch3 pending 6; sync applies it.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 16'd2);
    cycle();
    checkOutput("sync ch0=2", '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 16'd3);
    cycle();
    checkOutput("wr ch1=3", '0, 5'b00010, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 16'd4);
    cycle();
    checkOutput("wr ch2=4", '0, 5'b00110, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3, 16'd5);
    cycle();
    checkOutput("wr ch3=5", '0, 5'b01110, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 16'd0);
    cycle();
    checkOutput("sync b", '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3, 16'd6);
    cycle();
    checkOutput("wr ch3=6", '0, 5'b01000, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 16'd0);
    cycle();
    checkOutput("sync c", '0, '0, 1'b1);
    nDiv = '{2, 3, 4, 6, 2};
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    for (int f = 1; f <= 12; f++) begin
      cycle();
      checkOutput($sformatf("aligned f%0d", f), tickPattern(f), '0, 1'b0);
    end

    // ch1 write 7 mid-period, then 5 on the boundary edge itself.
    for (int f = 13; f <= 27; f++) begin
      if (f == 14)      applyStimulus(1'b1, 1'b0, 1'b1, 3'd1, 16'd7);
      else if (f == 15) applyStimulus(1'b1, 1'b0, 1'b1, 3'd1, 16'd5);
      else              applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
      t = tickPattern(f);
      t[1] = (f == 15) || (f == 22) || (f == 27);
      p = ((f >= 14) && (f <= 21)) ? 5'b00010 : 5'b00000;
      cycle();
      checkOutput($sformatf("collide f%0d", f), t, p, 1'b0);
    end

    // ch0 divisor 0 acts as 1; out-of-range channel writes are dropped.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 16'd0);
    cycle();
    checkOutput("sync ch0=0", '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 16'd9);
    cycle();
    checkOutput("wr ch5", '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd7, 16'd9);
    cycle();
    checkOutput("wr ch7", '0, '0, 1'b0);
    nDiv = '{1, 5, 4, 6, 2};
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    for (int f = 1; f <= 6; f++) begin
      cycle();
      checkOutput($sformatf("n1 f%0d", f), tickPattern(f), '0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, 16'd9);
    cycle();
    checkOutput("n1 f7 wr ch2", tickPattern(7), 5'b00100, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'd0);

    // Asynchronous clear between edges, then defaults come back.
    #3;
    clr_n = 1'b0;
    #1;
    checkOutput("async clr", '0, '0, 1'b1);
    #2;
    clr_n = 1'b1;
    nDiv = '{2, 2, 2, 2, 2};
    for (int f = 1; f <= 4; f++) begin
      cycle();
      checkOutput($sformatf("post clr f%0d", f), tickPattern(f), '0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
